// File: rtl/icache_direct_if.sv
// Memory-controller port of the instruction cache: single-word read request and the shared response bus.
interface icache_direct_if;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic        mem_r_nw_out;
    logic [2:0]  mem_type_out;
    logic        mem_activate_out;
    logic [31:0] mem_data_in;
    logic        mem_avail_in;
    logic [1:0]  mem_src_in;
    logic        icache_block_in;

    modport master (
        output mem_addr_out, mem_data_out, mem_r_nw_out, mem_type_out, mem_activate_out,
        input  mem_data_in, mem_avail_in, mem_src_in, icache_block_in
    );

    modport slave (
        input  mem_addr_out, mem_data_out, mem_r_nw_out, mem_type_out, mem_activate_out,
        output mem_data_in, mem_avail_in, mem_src_in, icache_block_in
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache; misses are filled by one word read from the controller.
// Defining ICACHE_PERF_EN adds the hit_cnt_out/miss_cnt_out performance counters.
module icache_direct #(
    parameter int INDEX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        fetch_req_in,
    input  logic [31:0] pc_in,
    output logic        fetch_ready_out,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
`ifdef ICACHE_PERF_EN
    output logic [31:0] hit_cnt_out,
    output logic [31:0] miss_cnt_out,
`endif
    icache_direct_if.master mem
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [29:0]        pc_q;
    logic [LINES-1:0]   line_valid;
    logic [TAG_W-1:0]   line_tag  [LINES];
    logic [31:0]        line_data [LINES];
    logic               inst_valid_q;
    logic [31:0]        inst_q;

    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               req_hit, issue_fire, resp_mine;
    logic               hit_accept, miss_accept, fill_en, deliver;
    logic               pc_unused;

    assign req_idx    = pc_in[INDEX_W+1:2];
    assign req_tag    = pc_in[31:INDEX_W+2];
    assign fill_idx   = pc_q[INDEX_W-1:0];
    assign fill_tag   = pc_q[29:INDEX_W];
    assign pc_unused  = ^pc_in[1:0];
    assign req_hit    = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign resp_mine  = mem.mem_avail_in && (mem.mem_src_in == 2'b10);
    assign issue_fire = (state_q == ST_ISSUE) && !mem.icache_block_in;

    assign fetch_ready_out      = (state_q == ST_IDLE);
    assign inst_valid_out       = inst_valid_q;
    assign inst_out             = inst_q;
    assign mem.mem_addr_out     = {pc_q, 2'b00};
    assign mem.mem_data_out     = 32'h0;
    assign mem.mem_r_nw_out     = 1'b1;
    assign mem.mem_type_out     = 3'b000;
    assign mem.mem_activate_out = issue_fire;

    // A flush during WAIT or an accepted issue leaves a read in flight, so DRAIN still absorbs and fills it.
    always_comb begin
        state_d     = state_q;
        hit_accept  = 1'b0;
        miss_accept = 1'b0;
        fill_en     = 1'b0;
        deliver     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_req_in && !flush_in) begin
                    if (req_hit) begin
                        hit_accept = 1'b1;
                    end else begin
                        miss_accept = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (flush_in) begin
                    state_d = issue_fire ? ST_DRAIN : ST_IDLE;
                end else if (issue_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resp_mine) begin
                    fill_en = 1'b1;
                    deliver = !flush_in;
                    state_d = ST_IDLE;
                end else if (flush_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (resp_mine) begin
                    fill_en = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            line_valid   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            inst_valid_q <= hit_accept || deliver;
            if (hit_accept) begin
                inst_q <= line_data[req_idx];
            end else if (deliver) begin
                inst_q <= mem.mem_data_in;
            end
            if (miss_accept) begin
                pc_q <= pc_in[31:2];
            end
            if (fill_en) begin
                line_valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage need no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_en) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= mem.mem_data_in;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_cnt_out  <= '0;
            miss_cnt_out <= '0;
        end else if (rdy_in) begin
            if (hit_accept) begin
                hit_cnt_out <= hit_cnt_out + 32'd1;
            end
            if (miss_accept) begin
                miss_cnt_out <= miss_cnt_out + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: a behavioural memory controller answers each read four cycles
// after it is issued, and every delivered instruction is matched against the queue of expected words.
module tb_icache_direct;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        fetch_req_in;
    logic [31:0] pc_in;
    logic        fetch_ready_out;
    logic        inst_valid_out;
    logic [31:0] inst_out;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_out;
    logic [31:0] miss_cnt_out;
`endif

    icache_direct_if mem_bus();

    icache_direct #(.INDEX_W(6)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .rdy_in          (rdy_in),
        .flush_in        (flush_in),
        .fetch_req_in    (fetch_req_in),
        .pc_in           (pc_in),
        .fetch_ready_out (fetch_ready_out),
        .inst_valid_out  (inst_valid_out),
        .inst_out        (inst_out),
`ifdef ICACHE_PERF_EN
        .hit_cnt_out     (hit_cnt_out),
        .miss_cnt_out    (miss_cnt_out),
`endif
        .mem             (mem_bus)
    );

    always #5 clk_in = ~clk_in;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          valid_count = 0;
    int          last_valid_cycle = 0;
    int          act_count = 0;
    int          act_attr_errs = 0;
    int          resp_timer = -1;
    int          exp_hits = 0;
    int          exp_misses = 0;
    bit          inject_foreign = 1'b0;
    logic [31:0] last_act_addr = 32'h0;
    logic [31:0] resp_addr = 32'h0;
    logic [31:0] sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h00A0_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    always @(posedge clk_in) cycle++;

    // Controller model: answers each accepted read 4 cycles later, optionally preceded by a foreign response.
    always @(negedge clk_in) begin
        mem_bus.mem_avail_in = 1'b0;
        mem_bus.mem_src_in   = 2'b00;
        mem_bus.mem_data_in  = 32'h0;
        if (resp_timer > 0) begin
            resp_timer--;
            if (resp_timer == 0) begin
                mem_bus.mem_avail_in = 1'b1;
                mem_bus.mem_src_in   = 2'b10;
                mem_bus.mem_data_in  = mem_word(resp_addr);
            end else if (inject_foreign && resp_timer == 2) begin
                mem_bus.mem_avail_in = 1'b1;
                mem_bus.mem_src_in   = 2'b01;
                mem_bus.mem_data_in  = 32'hDEAD_BEEF;
            end
        end
        if (mem_bus.mem_activate_out && rdy_in) begin
            act_count++;
            last_act_addr = mem_bus.mem_addr_out;
            if (mem_bus.mem_type_out != 3'b000 || !mem_bus.mem_r_nw_out || mem_bus.mem_data_out != 32'h0)
                act_attr_errs++;
            resp_addr  = mem_bus.mem_addr_out;
            resp_timer = 4;
        end
    end

    always @(negedge clk_in) begin
        if (rst_n_in && inst_valid_out && rdy_in) begin
            valid_count++;
            last_valid_cycle = cycle;
            if (sb.size() == 0) checkOutput("unexpected_valid", 32'd1, 32'd0);
            else checkOutput("inst_data", inst_out, sb.pop_front());
        end
    end

    task automatic checkResetValues();
        checkOutput("rst_fetch_ready", 32'(fetch_ready_out), 32'd1);
        checkOutput("rst_inst_valid", 32'(inst_valid_out), 32'd0);
        checkOutput("rst_inst_out", inst_out, 32'd0);
        checkOutput("rst_mem_activate", 32'(mem_bus.mem_activate_out), 32'd0);
        checkOutput("rst_mem_addr", mem_bus.mem_addr_out, 32'd0);
        checkOutput("rst_mem_r_nw", 32'(mem_bus.mem_r_nw_out), 32'd1);
        checkOutput("rst_mem_type", 32'(mem_bus.mem_type_out), 32'd0);
        checkOutput("rst_mem_data", mem_bus.mem_data_out, 32'd0);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input int exp_lat, input int exp_acts, input int block_cycles);
        int acts0;
        int vc0;
        int req_cycle;
        for (int i = 0; i < 100 && !fetch_ready_out; i++) step();
        acts0     = act_count;
        vc0       = valid_count;
        req_cycle = cycle;
        sb.push_back(mem_word(pc));
        if (exp_acts == 0) exp_hits++;
        else exp_misses++;
        pc_in                   = pc;
        fetch_req_in            = 1'b1;
        mem_bus.icache_block_in = (block_cycles > 0);
        step();
        fetch_req_in = 1'b0;
        for (int i = 0; i < block_cycles; i++) begin
            checkOutput("blocked_activate", 32'(mem_bus.mem_activate_out), 32'd0);
            step();
        end
        mem_bus.icache_block_in = 1'b0;
        for (int i = 0; i < 60 && valid_count == vc0; i++) step();
        if (valid_count == vc0) checkOutput("valid_timeout", 32'd0, 32'd1);
        else checkOutput("latency", last_valid_cycle - req_cycle, exp_lat);
        checkOutput("mem_activations", act_count - acts0, exp_acts);
        if (exp_acts > 0) checkOutput("mem_addr", last_act_addr, {pc[31:2], 2'b00});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acts0;
        int vc0;
        rst_n_in                = 1'b0;
        rdy_in                  = 1'b1;
        flush_in                = 1'b0;
        fetch_req_in            = 1'b0;
        pc_in                   = 32'h0;
        mem_bus.icache_block_in = 1'b0;
        repeat (2) step();
        checkResetValues();
        rst_n_in = 1'b1;

        $display("[TB] cold miss, hit, conflict misses");
        applyStimulus(32'h0000_0100, 6, 1, 0);
        applyStimulus(32'h0000_0100, 1, 0, 0);
        applyStimulus(32'h0000_0200, 6, 1, 0);
        applyStimulus(32'h0000_0100, 6, 1, 0);
        applyStimulus(32'h0000_0104, 6, 1, 0);
        applyStimulus(32'h0000_0104, 1, 0, 0);

        $display("[TB] blocked issue and foreign response");
        applyStimulus(32'h0000_0208, 9, 1, 3);
        inject_foreign = 1'b1;
        applyStimulus(32'h0000_030C, 6, 1, 0);
        inject_foreign = 1'b0;

        $display("[TB] flush in IDLE");
        vc0          = valid_count;
        acts0        = act_count;
        pc_in        = 32'h0000_0104;
        fetch_req_in = 1'b1;
        flush_in     = 1'b1;
        step();
        fetch_req_in = 1'b0;
        flush_in     = 1'b0;
        repeat (3) step();
        checkOutput("flush_idle_valid", valid_count - vc0, 32'd0);
        checkOutput("flush_idle_acts", act_count - acts0, 32'd0);

        $display("[TB] flush in ISSUE while blocked");
        acts0 = act_count;
        exp_misses++;
        pc_in                   = 32'h0000_0400;
        fetch_req_in            = 1'b1;
        mem_bus.icache_block_in = 1'b1;
        step();
        fetch_req_in = 1'b0;
        checkOutput("issue_not_ready", 32'(fetch_ready_out), 32'd0);
        flush_in = 1'b1;
        step();
        flush_in                = 1'b0;
        mem_bus.icache_block_in = 1'b0;
        checkOutput("issue_flush_ready", 32'(fetch_ready_out), 32'd1);
        repeat (6) step();
        checkOutput("issue_flush_acts", act_count - acts0, 32'd0);

        $display("[TB] flush in WAIT");
        acts0 = act_count;
        vc0   = valid_count;
        exp_misses++;
        pc_in        = 32'h0000_0500;
        fetch_req_in = 1'b1;
        step();
        fetch_req_in = 1'b0;
        repeat (2) step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        checkOutput("drain_not_ready", 32'(fetch_ready_out), 32'd0);
        repeat (2) step();
        checkOutput("drain_ready", 32'(fetch_ready_out), 32'd1);
        repeat (3) step();
        checkOutput("drain_no_valid", valid_count - vc0, 32'd0);
        checkOutput("drain_acts", act_count - acts0, 32'd1);
        applyStimulus(32'h0000_0500, 1, 0, 0);

        $display("[TB] rdy_in freeze");
        vc0 = valid_count;
        sb.push_back(mem_word(32'h0000_0500));
        exp_hits++;
        pc_in        = 32'h0000_0500;
        fetch_req_in = 1'b1;
        step();
        fetch_req_in = 1'b0;
        rdy_in       = 1'b0;
        repeat (2) step();
        checkOutput("freeze_valid_held", 32'(inst_valid_out), 32'd1);
        checkOutput("freeze_inst_held", inst_out, mem_word(32'h0000_0500));
        step();
        rdy_in = 1'b1;
        step();
        checkOutput("freeze_valid_cleared", 32'(inst_valid_out), 32'd0);
        checkOutput("freeze_single_delivery", valid_count - vc0, 32'd1);

        checkOutput("mem_attr_errors", act_attr_errs, 32'd0);
`ifdef ICACHE_PERF_EN
        checkOutput("hit_cnt", hit_cnt_out, exp_hits);
        checkOutput("miss_cnt", miss_cnt_out, exp_misses);
`endif

        $display("[TB] reset during WAIT");
        vc0          = valid_count;
        pc_in        = 32'h0000_0600;
        fetch_req_in = 1'b1;
        step();
        fetch_req_in = 1'b0;
        repeat (2) step();
        rst_n_in = 1'b0;
        #1;
        checkResetValues();
        step();
        rst_n_in = 1'b1;
        repeat (6) step();
        checkOutput("post_reset_no_valid", valid_count - vc0, 32'd0);
        applyStimulus(32'h0000_0600, 6, 1, 0);
        applyStimulus(32'h0000_0104, 6, 1, 0);

        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
